// File: rtl/prom_fetch_arbiter.sv
// Program ROM arbiter: CPU fetch vs AUX read, two-cycle registered pipeline.
// Optional PROM_BOUNDS_EN adds bounds_err and zeroes out-of-range responses.
module prom_fetch_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned ROM_DEPTH  = 32'h008F
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_flush,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef PROM_BOUNDS_EN
   ,output logic              bounds_err
`endif
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic [7:0]        starve;
    logic              aux_win;
    logic              t1_vld;
    logic              t1_cpu;
    logic              cpu_vld_q;
    logic              aux_vld_q;
    logic              cap_cpu;
    logic              cap_aux;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] rdata;

    assign aux_win = aux_req && (starve == SMAX);
    assign cpu_gnt = RSTn && cpu_req && !aux_win;
    assign aux_gnt = RSTn && aux_req && (aux_win || !cpu_req);

    // Flush kills a CPU word both while it is in the ROM cycle and on its valid cycle
    assign cap_cpu   = t1_vld && t1_cpu && !cpu_flush;
    assign cap_aux   = t1_vld && !t1_cpu;
    assign cpu_valid = cpu_vld_q && !cpu_flush;
    assign aux_valid = aux_vld_q;

    always_comb begin
        gaddr = aux_addr;
        if (cpu_gnt)
            gaddr = cpu_addr;
    end

`ifdef PROM_BOUNDS_EN
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(ROM_DEPTH);

    logic t1_oob;
    logic bnd_q;
    logic bnd_cpu_q;

    assign rdata      = t1_oob ? '0 : rom_data;
    assign bounds_err = bnd_q && !(bnd_cpu_q && cpu_flush);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            t1_oob    <= 1'b0;
            bnd_q     <= 1'b0;
            bnd_cpu_q <= 1'b0;
        end else begin
            t1_oob    <= (cpu_gnt || aux_gnt) && (gaddr >= DEPTH);
            bnd_q     <= t1_oob && (cap_cpu || cap_aux);
            bnd_cpu_q <= t1_cpu;
        end
    end
`else
    assign rdata = rom_data;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            starve    <= '0;
            rom_addr  <= '0;
            t1_vld    <= 1'b0;
            t1_cpu    <= 1'b0;
            cpu_vld_q <= 1'b0;
            aux_vld_q <= 1'b0;
            cpu_data  <= '0;
            aux_data  <= '0;
        end else begin
            if (aux_req && !aux_gnt)
                starve <= (starve == SMAX) ? SMAX : starve + 8'd1;
            else
                starve <= '0;
            if (cpu_gnt || aux_gnt)
                rom_addr <= gaddr;
            t1_vld    <= cpu_gnt || aux_gnt;
            t1_cpu    <= cpu_gnt;
            cpu_vld_q <= cap_cpu;
            aux_vld_q <= cap_aux;
            if (cap_cpu)
                cpu_data <= rdata;
            if (cap_aux)
                aux_data <= rdata;
        end
    end

endmodule
